// File: rtl/ps2_keyboard_tracker_pkg.sv
// Shared scan-code constants, decoder state type and arrow lookup for the
// PS/2 arrow-key tracker.
package ps2_keyboard_tracker_pkg;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  // Flag vector ordering used throughout: {left, right, up, down}
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    case (code)
      CODE_LEFT:  arrow_mask = 4'b1000;
      CODE_RIGHT: arrow_mask = 4'b0100;
      CODE_UP:    arrow_mask = 4'b0010;
      CODE_DOWN:  arrow_mask = 4'b0001;
      default:    arrow_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_keyboard_tracker_rx.sv
// PS/2 device-to-host byte receiver: line synchronizers, falling-edge detect,
// 11-bit frame assembly with start/parity/stop check, and stall timeout.
module ps2_byte_rx
  import ps2_keyboard_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       byte_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic          frame_ok;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift;
  logic [TW-1:0] timer;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
      dat_s1   <= 1'b0;
      dat_s2   <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // On the 11th edge the stop bit is still on the line, the rest sits in shift
  assign frame_ok = ~shift[0] & (^shift[9:1]) & dat_s2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt    <= 4'd0;
      shift      <= 10'd0;
      timer      <= '0;
      data       <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (fall) begin
        timer <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            data       <= shift[8:1];
            byte_valid <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shift   <= {dat_s2, shift[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (timer == TIMEOUT_LAST) begin
          bit_cnt <= 4'd0;
          timer   <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_tracker.sv
// PS/2 arrow-key tracker: decodes E0-prefixed arrow make/break sequences into
// four direction flags, either held levels or one-cycle press pulses.
module ps2_keyboard_tracker
  import ps2_keyboard_tracker_pkg::*;
#(
  parameter bit PULSE_OR_HOLD  = 1'b0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  inout  wire  PS2_CLK,
  inout  wire  PS2_DAT,
  output logic left,
  output logic right,
  output logic up,
  output logic down
);

  logic [7:0] rx_data;
  logic       rx_valid;
  dec_state_t state, state_next;
  logic [3:0] make_now, brk_now;
  logic [3:0] make_evt, brk_evt;
  logic [3:0] held;
  logic [3:0] flags;

  ps2_byte_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk    (PS2_CLK),
    .ps2_dat    (PS2_DAT),
    .data       (rx_data),
    .byte_valid (rx_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == CODE_EXT)      state_next = ST_EXT;
          else if (rx_data == CODE_BRK) state_next = ST_BRK;
        end
        ST_EXT: begin
          if (rx_data == CODE_BRK) state_next = ST_EXT_BRK;
          else                     state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    make_now = 4'b0000;
    brk_now  = 4'b0000;
    if (rx_valid) begin
      if (state == ST_EXT && rx_data != CODE_BRK) make_now = arrow_mask(rx_data);
      if (state == ST_EXT_BRK)                    brk_now  = arrow_mask(rx_data);
    end
  end

  // Events are registered once, then folded into the flags on the next cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      make_evt <= 4'b0000;
      brk_evt  <= 4'b0000;
      held     <= 4'b0000;
      flags    <= 4'b0000;
    end else begin
      make_evt <= make_now;
      brk_evt  <= brk_now;
      held     <= (held | make_evt) & ~brk_evt;
      if (PULSE_OR_HOLD) flags <= make_evt & ~held;
      else               flags <= (flags | make_evt) & ~brk_evt;
    end
  end

  assign {left, right, up, down} = flags;

endmodule

// File: tb/tb_ps2_keyboard_tracker.sv
// Directed bench for ps2_keyboard_tracker: a hold-mode and a pulse-mode
// instance share one emulated keyboard.
module tb_ps2_keyboard_tracker;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 8;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic [3:0] exp_hold;
    logic [3:0] exp_pulse;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk_drv = 1'b1;
  logic ps2_dat_drv = 1'b1;
  wire  ps2_clk_w;
  wire  ps2_dat_w;
  assign ps2_clk_w = ps2_clk_drv;
  assign ps2_dat_w = ps2_dat_drv;

  logic h_left, h_right, h_up, h_down;
  logic p_left, p_right, p_up, p_down;

  int passed = 0;
  int total  = 0;
  int pulse_cnt [4] = '{0, 0, 0, 0};
  int high_cnt  [4] = '{0, 0, 0, 0};
  logic [3:0] prev_p = 4'b0000;
  vec_t vecs[$];

  ps2_keyboard_tracker #(.PULSE_OR_HOLD(1'b0), .TIMEOUT_CYCLES(TIMEOUT)) dut_hold (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .left(h_left), .right(h_right), .up(h_up), .down(h_down)
  );

  ps2_keyboard_tracker #(.PULSE_OR_HOLD(1'b1), .TIMEOUT_CYCLES(TIMEOUT)) dut_pulse (
    .clock(clock), .reset(reset), .PS2_CLK(ps2_clk_w), .PS2_DAT(ps2_dat_w),
    .left(p_left), .right(p_right), .up(p_up), .down(p_down)
  );

  always #10 clock = ~clock;

  // Pulse-mode activity: number of rising edges and high cycles per flag
  always @(negedge clock) begin
    logic [3:0] pv;
    pv = {p_left, p_right, p_up, p_down};
    for (int k = 0; k < 4; k++) begin
      if (pv[k]) high_cnt[k]++;
      if (pv[k] && !prev_p[k]) pulse_cnt[k]++;
    end
    prev_p = pv;
  end

  initial begin
    repeat (90000) @(posedge clock);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  function automatic logic [3:0] hold_flags();
    return {h_left, h_right, h_up, h_down};
  endfunction

  function automatic logic [3:0] pulse_flags();
    return {p_left, p_right, p_up, p_down};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge clock);
    ps2_dat_drv = v;
    repeat (HALF) @(negedge clock);
    ps2_clk_drv = 1'b0;
    repeat (HALF) @(negedge clock);
    ps2_clk_drv = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic bad, input int nbits);
    logic [10:0] f;
    f = frame_bits(code, bad);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    repeat (20) @(negedge clock);
  endtask

  task automatic snap(output int pc[4], output int hc[4]);
    for (int k = 0; k < 4; k++) begin
      pc[k] = pulse_cnt[k];
      hc[k] = high_cnt[k];
    end
  endtask

  task automatic check_pulses(input string name, input int pc0[4], input int hc0[4],
                              input logic [3:0] exp);
    logic [15:0] dp, dh, ex;
    for (int k = 0; k < 4; k++) begin
      dp[4*k +: 4] = 4'(pulse_cnt[k] - pc0[k]);
      dh[4*k +: 4] = 4'(high_cnt[k] - hc0[k]);
      ex[4*k +: 4] = {3'b000, exp[k]};
    end
    checkOutput({name, " pulses"}, dp, ex);
    checkOutput({name, " width"}, dh, ex);
  endtask

  task automatic addVec(input logic [7:0] c, input logic b, input logic [3:0] h, input logic [3:0] p);
    vecs.push_back('{c, b, h, p});
  endtask

  initial begin
    int pc0[4];
    int hc0[4];
    logic [10:0] f;

    repeat (5) @(negedge clock);
    checkOutput("reset hold", {12'd0, hold_flags()}, 16'h0000);
    checkOutput("reset pulse", {12'd0, pulse_flags()}, 16'h0000);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    checkOutput("post-reset hold", {12'd0, hold_flags()}, 16'h0000);

    // flags {left,right,up,down}; pulse column = pulses expected from this byte
    addVec(8'hE0, 0, 4'b0000, 4'b0000);
    addVec(8'h75, 0, 4'b0010, 4'b0010);
    addVec(8'hE0, 0, 4'b0010, 4'b0000);
    addVec(8'hF0, 0, 4'b0010, 4'b0000);
    addVec(8'h75, 0, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 4'b0000, 4'b0000);
    addVec(8'h74, 0, 4'b0100, 4'b0100);
    addVec(8'hE0, 0, 4'b0100, 4'b0000);
    addVec(8'h72, 0, 4'b0101, 4'b0001);
    addVec(8'hE0, 0, 4'b0101, 4'b0000);
    addVec(8'hF0, 0, 4'b0101, 4'b0000);
    addVec(8'h74, 0, 4'b0001, 4'b0000);
    addVec(8'hE0, 0, 4'b0001, 4'b0000);
    addVec(8'hF0, 0, 4'b0001, 4'b0000);
    addVec(8'h72, 0, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 4'b0000, 4'b0000);
    addVec(8'h75, 1, 4'b0000, 4'b0000);
    addVec(8'h1C, 0, 4'b0000, 4'b0000);
    addVec(8'h6B, 0, 4'b0000, 4'b0000);
    addVec(8'h75, 0, 4'b0000, 4'b0000);
    addVec(8'hF0, 0, 4'b0000, 4'b0000);
    addVec(8'h74, 0, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 4'b0000, 4'b0000);
    addVec(8'h6B, 0, 4'b1000, 4'b1000);
    addVec(8'hE0, 0, 4'b1000, 4'b0000);
    addVec(8'h6B, 0, 4'b1000, 4'b0000);
    addVec(8'hE0, 0, 4'b1000, 4'b0000);
    addVec(8'h6B, 0, 4'b1000, 4'b0000);
    addVec(8'hE0, 0, 4'b1000, 4'b0000);
    addVec(8'hF0, 0, 4'b1000, 4'b0000);
    addVec(8'h6B, 0, 4'b0000, 4'b0000);
    addVec(8'hE0, 0, 4'b0000, 4'b0000);
    addVec(8'h6B, 0, 4'b1000, 4'b1000);
    addVec(8'hE0, 0, 4'b1000, 4'b0000);
    addVec(8'hF0, 0, 4'b1000, 4'b0000);
    addVec(8'h6B, 0, 4'b0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      snap(pc0, hc0);
      applyStimulus(vecs[i].code, vecs[i].bad_par, 11);
      checkOutput($sformatf("vec%0d hold", i), {12'd0, hold_flags()}, {12'd0, vecs[i].exp_hold});
      check_pulses($sformatf("vec%0d", i), pc0, hc0, vecs[i].exp_pulse);
    end

    // Exact latency from the final falling edge of E0 75
    applyStimulus(8'hE0, 0, 11);
    f = frame_bits(8'h75, 0);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    @(negedge clock);
    ps2_dat_drv = f[10];
    repeat (HALF) @(negedge clock);
    ps2_clk_drv = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("latency-3 hold", {12'd0, hold_flags()}, 16'h0000);
    checkOutput("latency-3 pulse", {12'd0, pulse_flags()}, 16'h0000);
    @(negedge clock);
    checkOutput("latency-4 hold", {12'd0, hold_flags()}, 16'h0002);
    checkOutput("latency-4 pulse", {12'd0, pulse_flags()}, 16'h0002);
    @(negedge clock);
    checkOutput("latency-5 hold", {12'd0, hold_flags()}, 16'h0002);
    checkOutput("latency-5 pulse", {12'd0, pulse_flags()}, 16'h0000);
    repeat (HALF - 2) @(negedge clock);
    ps2_clk_drv = 1'b1;
    repeat (20) @(negedge clock);

    // Asynchronous reset while up is held and a frame is half sent
    applyStimulus(8'hE0, 0, 5);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 checkOutput("async reset hold", {12'd0, hold_flags()}, 16'h0000);
    checkOutput("async reset pulse", {12'd0, pulse_flags()}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    snap(pc0, hc0);
    applyStimulus(8'hE0, 0, 11);
    applyStimulus(8'h75, 0, 11);
    checkOutput("after reset hold", {12'd0, hold_flags()}, 16'h0002);
    check_pulses("after reset", pc0, hc0, 4'b0010);
    applyStimulus(8'hE0, 0, 11);
    applyStimulus(8'hF0, 0, 11);
    applyStimulus(8'h75, 0, 11);
    checkOutput("after reset break", {12'd0, hold_flags()}, 16'h0000);

    // Abandoned partial frame must be discarded by the stall timeout
    applyStimulus(8'h1C, 0, 5);
    repeat (2 * TIMEOUT) @(negedge clock);
    snap(pc0, hc0);
    applyStimulus(8'hE0, 0, 11);
    applyStimulus(8'h72, 0, 11);
    checkOutput("timeout hold", {12'd0, hold_flags()}, 16'h0001);
    check_pulses("timeout", pc0, hc0, 4'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
